image_padding_ctrl: RTL and testbench
=====================================

Name: image_padding_ctrl

Overview:
- Read-side controller directly downstream of the image padding FIFO.
- Pops one image row at a time and emits a zero-padded frame, one pixel per cycle, to the next stage (line buffer / window generator).
- Adds a 1-pixel zero border on all four sides when padding is enabled; otherwise acts as a row-paced pass-through.

Parameters:
- WIDTH, 8, pixel/data width.
- ADDR_BITS, 11, width of FIFO occupancy counts and of the row/column size fields.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; latches sizes and begins a frame (ignored unless IDLE).
- row_num  in  ADDR_BITS  image rows (1..1024).
- col_num  in  ADDR_BITS  image columns (1..1024).
- pad_en  in  1  1 = add 1-pixel zero border, 0 = no border.
- fifo_m_count  out  ADDR_BITS  row-ready threshold to the FIFO; equals the latched col_num.
- fifo_m_valid  in  1  FIFO holds at least fifo_m_count words.
- fifo_rd_en  out  1  FIFO pop; FIFO data appears one cycle later (standard, non-FWFT).
- fifo_dout  in  WIDTH  FIFO read data.
- dst_ready  in  1  downstream can accept a full output row.
- dout  out  WIDTH  padded pixel.
- dout_valid  out  1  dout qualifier.
- row_last  out  1  high with the last pixel of each output row.
- done  out  1  one-cycle pulse after the last pixel of the frame.

Behaviour:
- Reset: all outputs 0 (fifo_m_count = 0); FSM goes to IDLE. A reset mid-frame aborts the frame with no further pops or outputs.
- Latch on start: R = row_num, C = col_num, P = pad_en. fifo_m_count = C from the next cycle onward.
- Output frame size: OR = R + 2P rows and OC = C + 2P columns, computed at ADDR_BITS+1 width with no overflow.
- FSM states:
  - IDLE: on start, go to WAIT_ROW.
  - WAIT_ROW: move to EMIT when dst_ready = 1 and either the current output row is a border row (P = 1 and orow = 0 or orow = OR-1) or fifo_m_valid = 1.
  - EMIT: ocol counts 0..OC-1, one per cycle. No stall within a row; dst_ready and fifo_m_valid are not sampled here. At ocol = OC-1, go to NEXT.
  - NEXT: if orow = OR-1, go to DONE; else orow++ and go to WAIT_ROW.
  - DONE: done = 1 for one cycle, then IDLE.
- fifo_rd_en = 1 in EMIT only for interior positions: row not a border row, and P ≤ ocol < C+P. Exactly C pops per interior row and R·C pops per frame.
- Output pipeline: 1-cycle latency from the EMIT position to dout_valid.
  - dout = fifo_dout if the previous cycle popped, else 0.
  - row_last is aligned with the pixel for ocol = OC-1.
- dout_valid totals: OR·OC pulses per frame, gapless within a row. At least one idle cycle separates rows (NEXT/WAIT_ROW).
- done asserts at least one cycle after the final dout_valid.
- start while not IDLE is ignored. Size inputs may change freely after start.
- Boundary cases:
  - R = 1, C = 1, P = 1 gives a 3x3 output with centre = the pixel.
  - P = 0 gives no zero outputs.

Decomposition:
- Shared package image_pkg holds:
  - FSM state encoding (IDLE, WAIT_ROW, EMIT, NEXT, DONE, 3-bit).
  - PAD_PIX = 1.
  - Default WIDTH and ADDR_BITS.
- One natural sub-module, image_pad_pos_cnt: the orow/ocol counter pair with border and interior decode, instanced once.

Test Plan:
- 3x3 image, pixels 1..9, pad_en = 1, dst_ready and fifo_m_valid held high:
  - 25 dout_valid pulses.
  - Row 0 and row 4 all zero; rows 1–3 read 0,1,2,3,0 / 0,4,5,6,0 / 0,7,8,9,0.
  - row_last on every 5th pixel; 9 pops; one done pulse.
- Same image, pad_en = 0 → 9 outputs 1..9, no zeros, row_last after pixels 3, 6 and 9.
- fifo_m_valid low for 20 cycles before the second interior row:
  - Top border row and first interior row emitted.
  - Controller holds in WAIT_ROW with fifo_rd_en = 0, then resumes and gives the correct values.
- dst_ready low at frame start → no dout_valid and no pops until it rises. Rows already in EMIT complete even if dst_ready drops mid-row.
- 1x1 image, value 0xA5, pad on → 3x3 output with only the centre = 0xA5. A start pulse mid-frame is ignored.
- rst asserted mid-row of a 4x4 frame → next cycle all outputs 0 and FSM in IDLE. A following start with a 2x2 image produces a correct 4x4 padded frame.

Source files
------------

// File: rtl/image_pkg.sv
// image_pkg: shared FSM encoding and defaults for the image padding read controller.
package image_pkg;
  localparam int PAD_PIX = 1;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_ADDR_BITS = 11;
  typedef enum logic [2:0] {IDLE, WAIT_ROW, EMIT, NEXT, DONE} state_t;
endpackage

// File: rtl/image_pad_pos_cnt.sv
// image_pad_pos_cnt: output row/column position counters with border and interior decode.
module image_pad_pos_cnt
  import image_pkg::*;
#(
  parameter int ADDR_BITS = DEF_ADDR_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_clr,
  input  logic                 i_col_en,
  input  logic                 i_row_en,
  input  logic                 i_pad,
  input  logic [ADDR_BITS-1:0] i_cols,
  input  logic [ADDR_BITS:0]   i_out_rows,
  input  logic [ADDR_BITS:0]   i_out_cols,
  output logic [ADDR_BITS:0]   o_orow,
  output logic [ADDR_BITS:0]   o_ocol,
  output logic                 o_border,
  output logic                 o_interior,
  output logic                 o_col_last,
  output logic                 o_row_last_row
);
  logic [ADDR_BITS:0] r_orow, r_ocol;
  logic [ADDR_BITS:0] w_pad;
  assign w_pad          = i_pad ? (ADDR_BITS+1)'(PAD_PIX) : '0;
  assign o_orow         = r_orow;
  assign o_ocol         = r_ocol;
  assign o_col_last     = r_ocol == i_out_cols - 1'b1;
  assign o_row_last_row = r_orow == i_out_rows - 1'b1;
  assign o_border       = i_pad && (r_orow == '0 || o_row_last_row);
  // Only interior positions map to real pixels and therefore to FIFO pops.
  assign o_interior     = !o_border && r_ocol >= w_pad && r_ocol < {1'b0, i_cols} + w_pad;
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_orow <= '0;
      r_ocol <= '0;
    end else begin
      if (i_col_en) r_ocol <= o_col_last ? '0 : r_ocol + 1'b1;
      if (i_row_en) r_orow <= r_orow + 1'b1;
    end
  end
endmodule

// File: rtl/image_padding_ctrl.sv
// image_padding_ctrl: pops rows from the padding FIFO and emits a zero-bordered frame,
// one pixel per cycle, with a one-cycle pipeline from emit position to dout.
module image_padding_ctrl
  import image_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int ADDR_BITS = DEF_ADDR_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_BITS-1:0] row_num,
  input  logic [ADDR_BITS-1:0] col_num,
  input  logic                 pad_en,
  output logic [ADDR_BITS-1:0] fifo_m_count,
  input  logic                 fifo_m_valid,
  output logic                 fifo_rd_en,
  input  logic [WIDTH-1:0]     fifo_dout,
  input  logic                 dst_ready,
  output logic [WIDTH-1:0]     dout,
  output logic                 dout_valid,
  output logic                 row_last,
  output logic                 done
);
  state_t               r_state;
  logic [ADDR_BITS-1:0] r_rows, r_cols;
  logic                 r_pad, r_pop, r_dv, r_last;
  logic [ADDR_BITS:0]   w_out_rows, w_out_cols, w_orow, w_ocol, w_pad2;
  logic                 w_border, w_interior, w_col_last, w_row_last_row;
  assign w_pad2       = r_pad ? (ADDR_BITS+1)'(2 * PAD_PIX) : '0;
  assign w_out_rows   = {1'b0, r_rows} + w_pad2;
  assign w_out_cols   = {1'b0, r_cols} + w_pad2;
  assign fifo_m_count = r_cols;
  assign fifo_rd_en   = r_state == EMIT && w_interior;
  // Non-FWFT FIFO: data for a pop arrives the cycle after, exactly when dout is presented.
  assign dout         = r_pop ? fifo_dout : '0;
  assign dout_valid   = r_dv;
  assign row_last     = r_last;
  assign done         = r_state == DONE;
  image_pad_pos_cnt #(.ADDR_BITS(ADDR_BITS)) u_pos (
    .clk           (clk),
    .rst           (rst),
    .i_clr         (r_state == IDLE && start),
    .i_col_en      (r_state == EMIT),
    .i_row_en      (r_state == NEXT && !w_row_last_row),
    .i_pad         (r_pad),
    .i_cols        (r_cols),
    .i_out_rows    (w_out_rows),
    .i_out_cols    (w_out_cols),
    .o_orow        (w_orow),
    .o_ocol        (w_ocol),
    .o_border      (w_border),
    .o_interior    (w_interior),
    .o_col_last    (w_col_last),
    .o_row_last_row(w_row_last_row)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_rows  <= '0;
      r_cols  <= '0;
      r_pad   <= 1'b0;
      r_pop   <= 1'b0;
      r_dv    <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      r_dv   <= r_state == EMIT;
      r_last <= r_state == EMIT && w_col_last;
      r_pop  <= fifo_rd_en;
      case (r_state)
        IDLE: if (start) begin
          r_rows  <= row_num;
          r_cols  <= col_num;
          r_pad   <= pad_en;
          r_state <= WAIT_ROW;
        end
        WAIT_ROW: if (dst_ready && (w_border || fifo_m_valid)) r_state <= EMIT;
        EMIT:     if (w_col_last) r_state <= NEXT;
        NEXT:     r_state <= w_row_last_row ? DONE : WAIT_ROW;
        DONE:     r_state <= IDLE;
        default:  r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_image_padding_ctrl.sv
// tb_image_padding_ctrl: directed checks of the padding controller against a queue-based FIFO.
module tb_image_padding_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [10:0] row_num = '0, col_num = '0;
  logic        pad_en = 1'b0;
  logic [10:0] fifo_m_count;
  logic        fifo_m_valid = 1'b1;
  logic        fifo_rd_en;
  logic [7:0]  fifo_dout = '0;
  logic        dst_ready = 1'b1;
  logic [7:0]  dout;
  logic        dout_valid, row_last, done;
  logic [7:0]  fq[$];
  logic [7:0]  got_d[$];
  logic        got_l[$];
  int          n_pop = 0, n_done = 0, n_chk = 0, n_err = 0;
  int          e[$];

  always #5 clk = ~clk;

  image_padding_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .row_num(row_num), .col_num(col_num),
    .pad_en(pad_en), .fifo_m_count(fifo_m_count), .fifo_m_valid(fifo_m_valid),
    .fifo_rd_en(fifo_rd_en), .fifo_dout(fifo_dout), .dst_ready(dst_ready),
    .dout(dout), .dout_valid(dout_valid), .row_last(row_last), .done(done)
  );

  always @(posedge clk)
    if (fifo_rd_en) begin
      if (fq.size() > 0) fifo_dout <= fq.pop_front();
      else fifo_dout <= 8'hEE;
    end

  always @(negedge clk)
    if (!rst) begin
      if (dout_valid) begin
        got_d.push_back(dout);
        got_l.push_back(row_last);
      end
      if (fifo_rd_en) n_pop++;
      if (done) n_done++;
    end

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_caps();
    got_d.delete();
    got_l.delete();
    n_pop = 0;
    n_done = 0;
  endtask

  task automatic begin_frame(input int r, input int c, input bit p, input int first, input int step);
    clear_caps();
    fq.delete();
    for (int i = 0; i < r * c; i++) fq.push_back(8'(first + i * step));
    @(posedge clk);
    #1;
    row_num = 11'(r);
    col_num = 11'(c);
    pad_en  = p;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    row_num = 11'd7;
    col_num = 11'd9;
    pad_en  = ~p;
  endtask

  task automatic wait_done(input string tag);
    int k;
    for (k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (done) break;
    end
    if (k == 3000) check({tag, " timeout"}, 0, 1);
    repeat (4) @(negedge clk);
  endtask

  task automatic check_frame(input string tag, input int exp[$], input int rowlen, input int pops);
    check({tag, " count"}, got_d.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got_d.size(); i++) begin
      check($sformatf("%s pix%0d", tag, i), int'(got_d[i]), exp[i]);
      check($sformatf("%s last%0d", tag, i), int'(got_l[i]), int'((i + 1) % rowlen == 0));
    end
    check({tag, " pops"}, n_pop, pops);
    check({tag, " done"}, n_done, 1);
  endtask

  initial begin
    int bad, k;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst dout_valid", int'(dout_valid), 0);
    check("rst dout", int'(dout), 0);
    check("rst row_last", int'(row_last), 0);
    check("rst done", int'(done), 0);
    check("rst rd_en", int'(fifo_rd_en), 0);
    check("rst m_count", int'(fifo_m_count), 0);
    rst = 1'b0;

    // 3x3 padded
    begin_frame(3, 3, 1'b1, 1, 1);
    @(negedge clk);
    check("m_count latched", int'(fifo_m_count), 3);
    wait_done("pad3");
    e = '{0,0,0,0,0, 0,1,2,3,0, 0,4,5,6,0, 0,7,8,9,0, 0,0,0,0,0};
    check_frame("pad3", e, 5, 9);

    // 3x3 pass-through
    begin_frame(3, 3, 1'b0, 1, 1);
    wait_done("nopad");
    e = '{1,2,3,4,5,6,7,8,9};
    check_frame("nopad", e, 3, 9);

    // stall before second interior row
    begin_frame(3, 3, 1'b1, 10, 10);
    k = 0;
    for (int i = 0; i < 200 && k < 2; i++) begin
      @(negedge clk);
      if (dout_valid && row_last) k++;
    end
    check("stall reach", k, 2);
    fifo_m_valid = 1'b0;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (fifo_rd_en || dout_valid) bad++;
    end
    check("stall idle", bad, 0);
    check("stall outs", got_d.size(), 10);
    fifo_m_valid = 1'b1;
    wait_done("stall");
    e = '{0,0,0,0,0, 0,10,20,30,0, 0,40,50,60,0, 0,70,80,90,0, 0,0,0,0,0};
    check_frame("stall", e, 5, 9);

    // dst_ready low at start, then dropped mid-row
    dst_ready = 1'b0;
    begin_frame(2, 2, 1'b1, 11, 1);
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (fifo_rd_en || dout_valid) bad++;
    end
    check("dst hold", bad, 0);
    dst_ready = 1'b1;
    k = 0;
    for (int i = 0; i < 50 && k == 0; i++) begin
      @(negedge clk);
      if (dout_valid) k = 1;
    end
    dst_ready = 1'b0;
    repeat (10) @(negedge clk);
    check("dst row done", got_d.size(), 4);
    dst_ready = 1'b1;
    wait_done("dst");
    e = '{0,0,0,0, 0,11,12,0, 0,13,14,0, 0,0,0,0};
    check_frame("dst", e, 4, 4);

    // 1x1 with ignored mid-frame start
    begin_frame(1, 1, 1'b1, 8'hA5, 0);
    repeat (3) @(negedge clk);
    row_num = 11'd5;
    col_num = 11'd5;
    pad_en  = 1'b0;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("one");
    e = '{0,0,0, 0,165,0, 0,0,0};
    check_frame("one", e, 3, 1);
    check("one m_count", int'(fifo_m_count), 1);

    // reset mid-row of a 4x4 frame
    begin_frame(4, 4, 1'b1, 1, 1);
    k = 0;
    for (int i = 0; i < 200 && k < 8; i++) begin
      @(negedge clk);
      if (dout_valid) k++;
    end
    check("mid reach", k, 8);
    rst = 1'b1;
    @(negedge clk);
    check("mid dout_valid", int'(dout_valid), 0);
    check("mid rd_en", int'(fifo_rd_en), 0);
    check("mid row_last", int'(row_last), 0);
    check("mid dout", int'(dout), 0);
    check("mid m_count", int'(fifo_m_count), 0);
    rst = 1'b0;
    clear_caps();
    repeat (5) @(negedge clk);
    check("post rst quiet", got_d.size() + n_pop, 0);
    begin_frame(2, 2, 1'b1, 21, 1);
    wait_done("after");
    e = '{0,0,0,0, 0,21,22,0, 0,23,24,0, 0,0,0,0};
    check_frame("after", e, 4, 4);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
